// File: rtl/mem_out_streamer.sv
// -----------------------------------------------------------------------------
// mem_out_streamer
//
// Purpose:
//   Snoops the single-cycle core's data-memory write bus and queues every
//   aligned store that lands inside a memory-mapped output window. Queued
//   entries are presented head-first on a valid/ready stream for the display
//   or serial peripheral. The core is never stalled: a store that arrives
//   while the queue is full (and nothing is popped that cycle) is dropped.
//
// Optional feature macro:
//   MEM_OUT_DROPCNT_EN - when defined, drop_count counts lost stores and
//                        saturates at 16'hFFFF. When undefined, no counter is
//                        built and drop_count is tied to zero.
//
// Parameters:
//   DEPTH        - queue entries, power of two, 2..64
//   BASE_ADDR    - first byte address of the output window, 4-byte aligned
//   WINDOW_WORDS - window size in 32-bit words, power of two, 1..256
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   MemWrite   in   core store strobe (same cycle as address/data)
//   DataAdr    in   core data byte address
//   WriteData  in   core store data
//   out_valid  out  head entry available
//   out_ready  in   consumer accepts the head this cycle
//   out_data   out  head entry store data
//   out_offset out  head entry word offset inside the window
//   count      out  number of entries held
//   full       out  count == DEPTH
//   drop_count out  stores lost to a full queue
// -----------------------------------------------------------------------------
module mem_out_streamer #(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          WINDOW_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [7:0]               out_offset,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Window size in bytes; compared against the unsigned distance from
  // BASE_ADDR so a single compare covers both window bounds.
  localparam logic [31:0] WINDOW_BYTES = 32'(4 * WINDOW_WORDS);

  // ---------------------------------------------------------------------------
  // Store decode
  // ---------------------------------------------------------------------------
  logic [31:0] w_rel;       // byte distance from the window base (mod 2^32)
  logic [7:0]  w_word_off;  // word offset of the store inside the window
  logic        w_hit;

  // Addresses below BASE_ADDR wrap to huge values, so "w_rel < WINDOW_BYTES"
  // is exactly BASE_ADDR <= DataAdr < BASE_ADDR + 4*WINDOW_WORDS. BASE_ADDR
  // is word aligned, so the low bits of w_rel equal the low address bits.
  assign w_rel      = DataAdr - BASE_ADDR;
  assign w_word_off = w_rel[9:2];
  assign w_hit      = MemWrite && (w_rel < WINDOW_BYTES) && (w_rel[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [39:0]   r_head;      // {offset, data} of the entry shown on the stream

  // Entry storage: {word offset, store data}. Not reset; only slots between
  // the pointers are ever observed.
  logic [39:0]   r_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_ptr_inc;
  logic [39:0]   w_new_entry;

  assign w_empty      = (r_count == CW'(0));
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pop        = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push       = w_hit && (!w_full || w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
  assign w_new_entry  = {w_word_off, WriteData};

  // ---------------------------------------------------------------------------
  // Head register selection
  //
  // The stream outputs come from r_head rather than straight from the array,
  // so they reset cleanly and never depend combinationally on the store bus.
  // After each edge r_head must hold the entry at the new read pointer:
  //   - pop with more than one entry left: the next array slot, which is
  //     already written (it can only be the write slot when count == 1);
  //   - queue becomes non-empty from empty (or refills in the same edge that
  //     pops its last entry): the incoming store itself;
  //   - otherwise the head is unchanged (or the queue is empty: hold).
  // ---------------------------------------------------------------------------
  logic        w_head_load;
  logic [39:0] w_head_next;

  always_comb begin
    w_head_load = 1'b0;
    w_head_next = r_mem[w_rd_ptr_inc];
    if (w_pop && (r_count > CW'(1))) begin
      w_head_load = 1'b1;
      w_head_next = r_mem[w_rd_ptr_inc];
    end else if (w_push && (w_empty || (w_pop && (r_count == CW'(1))))) begin
      w_head_load = 1'b1;
      w_head_next = w_new_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Array write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and head
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_head_load) begin
        r_head <= w_head_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter
  // ---------------------------------------------------------------------------
`ifdef MEM_OUT_DROPCNT_EN
  logic        w_drop;
  logic [15:0] r_drop_count;

  assign w_drop = w_hit && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state
  // ---------------------------------------------------------------------------
  assign out_valid  = !w_empty;
  assign out_data   = r_head[31:0];
  assign out_offset = r_head[39:32];
  assign count      = r_count;
  assign full       = w_full;

endmodule

// File: tb/tb_mem_out_streamer.sv
// -----------------------------------------------------------------------------
// tb_mem_out_streamer
//
// Directed bench for mem_out_streamer with the default parameters
// (DEPTH=8, BASE_ADDR=0x1000, WINDOW_WORDS=16). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, i.e. they show
// the effect of the edge just taken and are stable until the next one.
// -----------------------------------------------------------------------------
module tb_mem_out_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_offset;
  logic [3:0]  count;
  logic        full;
  logic [15:0] drop_count;

`ifdef MEM_OUT_DROPCNT_EN
  localparam logic [31:0] EXP_DROP = 32'd2;
`else
  localparam logic [31:0] EXP_DROP = 32'd0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] got_d[$];
  logic [7:0]  got_o[$];

  mem_out_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_offset (out_offset),
    .count      (count),
    .full       (full),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    $display("store adr=0x%08h data=0x%08h -> count=%0d", a, d, count);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic [7:0] off);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".off"}, 32'(out_offset), 32'(off));
    $display("pop data=0x%08h off=%0d", out_data, out_offset);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset values (asynchronous) ----------------
    #2 reset = 1'b1;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.data", out_data, 32'd0);
    chk("rst.off", 32'(out_offset), 32'd0);
    chk("rst.drop", 32'(drop_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // ---------------- 1: three stores, then drain ----------------
    store(32'h1000, 32'hA);
    chk("t1.lat.valid", 32'(out_valid), 32'd1);
    chk("t1.lat.data", out_data, 32'hA);
    store(32'h1004, 32'hB);
    store(32'h103C, 32'hC);
    chk("t1.count", 32'(count), 32'd3);
    chk("t1.full", 32'(full), 32'd0);
    pop_expect("t1.p0", 32'hA, 8'd0);
    pop_expect("t1.p1", 32'hB, 8'd1);
    pop_expect("t1.p2", 32'hC, 8'd15);
    chk("t1.empty", 32'(out_valid), 32'd0);
    chk("t1.count0", 32'(count), 32'd0);

    // ---------------- 2: misses ----------------
    store(32'h0FFC, 32'h11);
    store(32'h1040, 32'h22);
    store(32'h1002, 32'h33);
    MemWrite  = 1'b0;
    DataAdr   = 32'h1000;
    WriteData = 32'h44;
    tick();
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    chk("t2.count", 32'(count), 32'd0);
    chk("t2.valid", 32'(out_valid), 32'd0);
    chk("t2.drop", 32'(drop_count), 32'd0);

    // ---------------- 3: overfill by two ----------------
    for (int i = 1; i <= 10; i++) store(32'h1000 + 32'(4 * (i - 1)), 32'(i));
    chk("t3.full", 32'(full), 32'd1);
    chk("t3.count", 32'(count), 32'd8);
    chk("t3.drop", 32'(drop_count), EXP_DROP);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("t3.p%0d", i), 32'(i), 8'(i - 1));
    chk("t3.empty", 32'(out_valid), 32'd0);
    chk("t3.fullclr", 32'(full), 32'd0);
    chk("t3.dropheld", 32'(drop_count), EXP_DROP);

    // ---------------- 4: push into full with simultaneous pop ----------------
    for (int i = 0; i < 8; i++) store(32'h1000 + 32'(4 * i), 32'h20 + 32'(i));
    chk("t4.full", 32'(full), 32'd1);
    chk("t4.head", out_data, 32'h20);
    MemWrite  = 1'b1;
    DataAdr   = 32'h1020;
    WriteData = 32'h55;
    out_ready = 1'b1;
    tick();
    MemWrite  = 1'b0;
    out_ready = 1'b0;
    $display("store adr=0x00001020 data=0x00000055 with pop -> count=%0d", count);
    chk("t4.count", 32'(count), 32'd8);
    chk("t4.stillfull", 32'(full), 32'd1);
    chk("t4.nodrop", 32'(drop_count), EXP_DROP);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("t4.p%0d", i), 32'h20 + 32'(i), 8'(i));
    pop_expect("t4.last", 32'h55, 8'd8);
    chk("t4.empty", 32'(out_valid), 32'd0);

    // ---------------- 5: streaming across pointer wrap ----------------
    // One store per cycle; the consumer applies back-pressure every fourth
    // cycle so the queue fills slowly but never overflows.
    for (int k = 0; k < 20; k++) begin
      MemWrite  = 1'b1;
      DataAdr   = 32'h1000 + 32'(4 * (k % 16));
      WriteData = 32'h100 + 32'(k);
      out_ready = ((k % 4) != 3);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_o.push_back(out_offset);
        $display("pop data=0x%08h off=%0d", out_data, out_offset);
      end
      tick();
    end
    MemWrite  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got_d.size() < 20; cyc++) begin
      if (out_valid) begin
        got_d.push_back(out_data);
        got_o.push_back(out_offset);
        $display("pop data=0x%08h off=%0d", out_data, out_offset);
      end
      tick();
    end
    out_ready = 1'b0;
    chk("t5.received", 32'(got_d.size()), 32'd20);
    for (int i = 0; i < 20 && i < got_d.size(); i++) begin
      chk($sformatf("t5.d%0d", i), got_d[i], 32'h100 + 32'(i));
      chk($sformatf("t5.o%0d", i), 32'(got_o[i]), 32'(i % 16));
    end
    chk("t5.empty", 32'(out_valid), 32'd0);
    chk("t5.drop", 32'(drop_count), EXP_DROP);

    // ---------------- 6: asynchronous reset mid-cycle ----------------
    for (int i = 0; i < 5; i++) store(32'h1000 + 32'(4 * i), 32'h30 + 32'(i));
    chk("t6.count5", 32'(count), 32'd5);
    #3 reset = 1'b1;
    #1;
    chk("t6.valid", 32'(out_valid), 32'd0);
    chk("t6.count", 32'(count), 32'd0);
    chk("t6.drop", 32'(drop_count), 32'd0);
    chk("t6.data", out_data, 32'd0);
    chk("t6.off", 32'(out_offset), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    // Empty queue, store and ready together: no bypass.
    MemWrite  = 1'b1;
    DataAdr   = 32'h1008;
    WriteData = 32'h77;
    out_ready = 1'b1;
    tick();
    MemWrite  = 1'b0;
    $display("store adr=0x00001008 data=0x00000077 -> count=%0d", count);
    chk("t6.nb.count", 32'(count), 32'd1);
    chk("t6.nb.valid", 32'(out_valid), 32'd1);
    chk("t6.nb.data", out_data, 32'h77);
    chk("t6.nb.off", 32'(out_offset), 32'd2);
    tick();
    out_ready = 1'b0;
    chk("t6.popped", 32'(count), 32'd0);
    chk("t6.empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
